// File: rtl/path_extractor_if.sv
// path_extractor_if
//   Bundles the two handshaked channels of the path extractor:
//   - memory read port : mem_read_enable / mem_addr (request, extractor drives)
//                        mem_read_data / mem_read_ready (completion, memory drives)
//   - path stream      : path_valid / path_node / path_last (extractor drives)
//                        path_ready (consumer drives)
//   Modports: master = path_extractor side, slave = memory + consumer side.
interface path_extractor_if #(
  parameter int INDEX_WIDTH = 8,
  parameter int MADDR_WIDTH = 32,
  parameter int MDATA_WIDTH = 32
);
  logic                   mem_read_enable;
  logic [MADDR_WIDTH-1:0] mem_addr;
  logic [MDATA_WIDTH-1:0] mem_read_data;
  logic                   mem_read_ready;
  logic                   path_valid;
  logic [INDEX_WIDTH-1:0] path_node;
  logic                   path_last;
  logic                   path_ready;

  modport master (
    output mem_read_enable, mem_addr, path_valid, path_node, path_last,
    input  mem_read_data, mem_read_ready, path_ready
  );

  modport slave (
    input  mem_read_enable, mem_addr, path_valid, path_node, path_last,
    output mem_read_data, mem_read_ready, path_ready
  );
endinterface

// File: rtl/path_extractor.sv
// path_extractor
//   Walks a predecessor array in memory from destination back to source,
//   stacking the visited nodes, then streams the path source-first.
//   Ports:
//     clock, reset          : clock, synchronous active-high reset
//     start                 : begin extraction (honoured in IDLE, DONE, ERR)
//     source, destination   : path endpoints, latched on start
//     number_of_nodes       : valid index bound, latched on start
//     prev_base_address     : byte address of prev[0]
//     bus (master)          : memory read port and path stream
//     path_length           : node count of the emitted path (0 after an error)
//     busy, done, error     : status flags
//     dbg_state             : current FSM state encoding
//
//   Handshakes: the memory request (mem_read_enable + mem_addr) is held
//   unchanged until mem_read_ready is sampled high on a clock edge, and drops
//   on that same edge. A path element transfers on every edge where
//   path_valid && path_ready; while path_ready is low the element and
//   path_last are held unchanged.
//
//   All outputs are flops whose next values are derived from the next state,
//   so an output reflects the state entered on the same edge.
module path_extractor #(
  parameter int MAX_NODES   = 16,
  parameter int INDEX_WIDTH = 8,
  parameter int MADDR_WIDTH = 32,
  parameter int MDATA_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [INDEX_WIDTH-1:0] source,
  input  logic [INDEX_WIDTH-1:0] destination,
  input  logic [INDEX_WIDTH-1:0] number_of_nodes,
  input  logic [MADDR_WIDTH-1:0] prev_base_address,
  path_extractor_if.master       bus,
  output logic [INDEX_WIDTH-1:0] path_length,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [2:0]             dbg_state
);

  localparam int DEPTH_W    = $clog2(MAX_NODES + 1);
  localparam int PTR_W      = $clog2(MAX_NODES);
  localparam int WORD_BYTES = MDATA_WIDTH / 8;
  localparam logic [INDEX_WIDTH-1:0] NO_PREVIOUS_NODE = '1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PUSH  = 3'd1,
    S_FETCH = 3'd2,
    S_CHECK = 3'd3,
    S_EMIT  = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  state_t state_q, state_d;

  // Datapath registers
  logic [INDEX_WIDTH-1:0] src_q,  src_d;
  logic [INDEX_WIDTH-1:0] nodes_q, nodes_d;
  logic [MADDR_WIDTH-1:0] base_q, base_d;
  logic [INDEX_WIDTH-1:0] cur_q,  cur_d;
  logic [INDEX_WIDTH-1:0] nxt_q,  nxt_d;
  logic [DEPTH_W-1:0]     depth_q, depth_d;
  logic [INDEX_WIDTH-1:0] stack_q [MAX_NODES];
  logic [INDEX_WIDTH-1:0] stack_d [MAX_NODES];

  // Output registers
  logic                   mem_read_enable_q, mem_read_enable_d;
  logic [MADDR_WIDTH-1:0] mem_addr_q,        mem_addr_d;
  logic                   path_valid_q,      path_valid_d;
  logic [INDEX_WIDTH-1:0] path_node_q,       path_node_d;
  logic                   path_last_q,       path_last_d;
  logic [INDEX_WIDTH-1:0] path_length_q,     path_length_d;
  logic                   busy_q,            busy_d;
  logic                   done_q,            done_d;
  logic                   error_q,           error_d;

  logic             accept;
  logic             fire;
  logic             bad_next;
  logic [PTR_W-1:0] push_idx;
  logic [PTR_W-1:0] pop_idx;

  assign accept   = start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);
  assign fire     = path_valid_q && bus.path_ready;
  assign bad_next = (nxt_q == NO_PREVIOUS_NODE) || (nxt_q >= nodes_q);
  assign push_idx = PTR_W'(depth_q);
  // Element that becomes the top of stack after a pop (depth-2 before the pop).
  assign pop_idx  = PTR_W'(depth_q - DEPTH_W'(2));

  // ---------------------------------------------------------------- state register
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: if (start) state_d = S_PUSH;
      S_PUSH: begin
        if (cur_q == src_q)                         state_d = S_EMIT;
        else if (depth_q == DEPTH_W'(MAX_NODES - 1)) state_d = S_ERR;  // this push fills the stack
        else                                        state_d = S_FETCH;
      end
      S_FETCH: if (bus.mem_read_ready) state_d = S_CHECK;
      S_CHECK: state_d = bad_next ? S_ERR : S_PUSH;
      S_EMIT:  if (fire && depth_q == DEPTH_W'(1)) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- datapath next values
  always_comb begin
    src_d   = src_q;
    nodes_d = nodes_q;
    base_d  = base_q;
    cur_d   = cur_q;
    nxt_d   = nxt_q;
    depth_d = depth_q;
    stack_d = stack_q;
    if (accept) begin
      src_d   = source;
      nodes_d = number_of_nodes;
      base_d  = prev_base_address;
      cur_d   = destination;
      depth_d = '0;
    end else begin
      case (state_q)
        S_PUSH: begin
          stack_d[push_idx] = cur_q;
          depth_d           = depth_q + DEPTH_W'(1);
        end
        S_FETCH: if (bus.mem_read_ready) nxt_d = bus.mem_read_data[INDEX_WIDTH-1:0];
        S_CHECK: if (!bad_next) cur_d = nxt_q;
        S_EMIT:  if (fire) depth_d = depth_q - DEPTH_W'(1);
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------- output next values
  always_comb begin
    mem_read_enable_d = (state_d == S_FETCH);
    mem_addr_d        = mem_addr_q;
    path_valid_d      = (state_d == S_EMIT);
    path_node_d       = path_node_q;
    path_last_d       = path_last_q;
    path_length_d     = path_length_q;
    busy_d            = (state_d == S_PUSH) || (state_d == S_FETCH) ||
                        (state_d == S_CHECK) || (state_d == S_EMIT);
    done_d            = (state_d == S_DONE);
    error_d           = (state_d == S_ERR);

    if (state_q == S_PUSH && state_d == S_FETCH)
      mem_addr_d = base_q + MADDR_WIDTH'(cur_q) * MADDR_WIDTH'(WORD_BYTES);

    if (state_q == S_PUSH && state_d == S_EMIT) begin
      // The source is being pushed this cycle, so it is forwarded directly
      // instead of read back from the stack.
      path_node_d   = cur_q;
      path_last_d   = (depth_q == '0);
      path_length_d = INDEX_WIDTH'(depth_q) + INDEX_WIDTH'(1);
    end else if (state_q == S_EMIT && fire && state_d == S_EMIT) begin
      path_node_d = stack_q[pop_idx];
      path_last_d = (depth_q == DEPTH_W'(2));
    end

    if (accept || state_d == S_ERR) path_length_d = '0;
  end

  // ---------------------------------------------------------------- registers
  always_ff @(posedge clock) begin
    if (reset) begin
      src_q             <= '0;
      nodes_q           <= '0;
      base_q            <= '0;
      cur_q             <= '0;
      nxt_q             <= '0;
      depth_q           <= '0;
      mem_read_enable_q <= 1'b0;
      mem_addr_q        <= '0;
      path_valid_q      <= 1'b0;
      path_node_q       <= '0;
      path_last_q       <= 1'b0;
      path_length_q     <= '0;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
      error_q           <= 1'b0;
    end else begin
      src_q             <= src_d;
      nodes_q           <= nodes_d;
      base_q            <= base_d;
      cur_q             <= cur_d;
      nxt_q             <= nxt_d;
      depth_q           <= depth_d;
      mem_read_enable_q <= mem_read_enable_d;
      mem_addr_q        <= mem_addr_d;
      path_valid_q      <= path_valid_d;
      path_node_q       <= path_node_d;
      path_last_q       <= path_last_d;
      path_length_q     <= path_length_d;
      busy_q            <= busy_d;
      done_q            <= done_d;
      error_q           <= error_d;
    end
  end

  // Stack contents are only meaningful below depth, so they need no reset.
  always_ff @(posedge clock) begin
    stack_q <= stack_d;
  end

  assign bus.mem_read_enable = mem_read_enable_q;
  assign bus.mem_addr        = mem_addr_q;
  assign bus.path_valid      = path_valid_q;
  assign bus.path_node       = path_node_q;
  assign bus.path_last       = path_last_q;
  assign path_length         = path_length_q;
  assign busy                = busy_q;
  assign done                = done_q;
  assign error               = error_q;
  assign dbg_state           = state_q;

endmodule
